// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_pkg
//  Brief    : Shared types and saturation helpers for the fixed-point
//             sequential divider.
//  Revision : 1.0 - initial release
// ============================================================================
package fxp_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest result the saturation helpers can describe
    localparam int unsigned c_sat_w_max = 64;

    // Largest positive two's-complement value of a w-bit word
    function automatic logic [c_sat_w_max-1:0] sat_max_pos(input int unsigned w);
        sat_max_pos = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit value (also its magnitude)
    function automatic logic [c_sat_w_max-1:0] sat_min_neg(input int unsigned w);
        sat_min_neg = 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_div_seq
//  Brief    : Iterative radix-2 restoring divider for signed fixed-point
//             operands. Works on magnitudes, one quotient bit per cycle,
//             one guard bit for rounding, saturating result.
//  Revision : 1.0 - initial release
// ============================================================================
module fxp_div_seq
    import fxp_pkg::*;
#(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1
) (
    input  logic                 rstn,
    input  logic                 clk,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WIIA+WIFA-1:0] dividend,
    input  logic [WIIB+WIFB-1:0] divisor,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 overflow
);

    localparam int c_wa    = WIIA + WIFA;
    localparam int c_wb    = WIIB + WIFB;
    localparam int c_wo    = WOI + WOF;
    localparam int c_n     = c_wo + 1;              // quotient bits incl. guard
    localparam int c_cw    = $clog2(c_n + 1);
    // Aligns |dividend| so that |num|/|div| carries WOF+1 fraction bits
    localparam int c_shift = WOF + 1 + WIFB - WIFA;
    localparam int c_shl   = (c_shift > 0) ? c_shift : 0;
    localparam int c_shr   = (c_shift < 0) ? -c_shift : 0;
    localparam int c_nw    = c_n + c_wb;
    localparam int c_xw    = ((c_wa + c_shl) > c_nw) ? (c_wa + c_shl) : c_nw;
    localparam int c_pa    = c_wa + WIFB;
    localparam int c_pb    = c_wb + WIFA + WOI - 1;
    localparam int c_pw    = ((c_pa > c_pb) ? c_pa : c_pb) + 1;

    localparam logic [c_cw-1:0] c_last    = c_cw'(c_n - 1);
    localparam logic [c_wo-1:0] c_max_pos = c_wo'(sat_max_pos(c_wo));
    localparam logic [c_wo-1:0] c_min_neg = c_wo'(sat_min_neg(c_wo));
    localparam logic [c_n-1:0]  c_lim_pos = c_n'(sat_max_pos(c_wo));
    localparam logic [c_n-1:0]  c_lim_neg = c_n'(sat_min_neg(c_wo));

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_cw-1:0]   r_cnt;
    logic [c_wb-1:0]   r_bmag;
    logic [c_wb-1:0]   r_rem;
    logic [c_n-1:0]    r_num_lo;
    logic [c_n-2:0]    r_q;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_ovf_pre;
    logic [c_wo-1:0]   r_out;
    logic              r_ovf;

    logic [c_wa-1:0]   w_amag;
    logic [c_wb-1:0]   w_bmag;
    logic [c_nw-1:0]   w_num;
    logic              w_pre_ovf;
    logic              w_last;
    logic [c_wb:0]     w_trial;
    logic              w_ge;
    logic [c_wb-1:0]   w_rem_nxt;
    logic [c_n-1:0]    w_q_full;
    logic [c_n-1:0]    w_q_half;
    logic [c_n-1:0]    w_mag;
    logic              w_neg;
    logic [c_wo-1:0]   w_res;
    logic              w_res_ovf;

    // Operand magnitudes; the most negative code maps to its true magnitude
    assign w_amag = dividend[c_wa-1] ? (~dividend + c_wa'(1)) : dividend;
    assign w_bmag = divisor[c_wb-1]  ? (~divisor + c_wb'(1))  : divisor;

    // Scaled numerator: upper c_wb bits seed the remainder, lower c_n bits are shifted in
    assign w_num = c_nw'((c_xw'(w_amag) << c_shl) >> c_shr);

    // Divide by zero, or |a|/|b| >= 2^(WOI-1) compared exactly in integers
    assign w_pre_ovf = (w_bmag == '0) ||
                       ((c_pw'(w_amag) << WIFB) >= (c_pw'(w_bmag) << (WIFA + WOI - 1)));

    assign w_last = (r_cnt == c_last);
    assign w_neg  = r_sign_a ^ r_sign_b;

    // One restoring step: shift in the next numerator bit, subtract if it fits
    always_comb begin
        w_trial   = {r_rem, r_num_lo[c_n-1]};
        w_ge      = (w_trial >= {1'b0, r_bmag});
        w_rem_nxt = w_ge ? c_wb'(w_trial - {1'b0, r_bmag}) : c_wb'(w_trial);
        w_q_full  = {r_q, w_ge};
    end

    // Guard-bit rounding (half away from zero on the magnitude) or truncation
    always_comb begin
        w_q_half = w_q_full >> 1;
        w_mag    = (ROUND != 0) ? (w_q_half + c_n'(w_q_full[0])) : w_q_half;
    end

    // Sign application and saturation of the final result
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        if (r_ovf_pre) begin
            w_res     = w_neg ? c_min_neg : c_max_pos;
            w_res_ovf = 1'b1;
        end else if (!w_neg && (w_mag > c_lim_pos)) begin
            w_res     = c_max_pos;
            w_res_ovf = 1'b1;
        end else if (w_neg && (w_mag > c_lim_neg)) begin
            w_res     = c_min_neg;
            w_res_ovf = 1'b1;
        end else begin
            w_res = w_neg ? c_wo'(~w_mag + c_n'(1)) : c_wo'(w_mag);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        i_ready     = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, iteration in CALC, result latch on the last step
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_bmag    <= '0;
            r_rem     <= '0;
            r_num_lo  <= '0;
            r_q       <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_ovf_pre <= 1'b0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_bmag    <= w_bmag;
                        r_rem     <= w_num[c_n +: c_wb];
                        r_num_lo  <= w_num[c_n-1:0];
                        r_q       <= '0;
                        r_cnt     <= '0;
                        r_sign_a  <= dividend[c_wa-1];
                        r_sign_b  <= divisor[c_wb-1];
                        r_ovf_pre <= w_pre_ovf;
                    end
                end
                CALC: begin
                    r_rem    <= w_rem_nxt;
                    r_num_lo <= r_num_lo << 1;
                    r_q      <= w_q_full[c_n-2:0];
                    r_cnt    <= r_cnt + c_cw'(1);
                    if (w_last) begin
                        r_out <= w_res;
                        r_ovf <= w_res_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out      = r_out;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fxp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fxp_div_seq
//  Brief    : Self-checking bench for fxp_div_seq (directed table, random
//             operands against an arithmetic reference, handshake corners).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_div_seq;

    localparam int WIIA  = 10;
    localparam int WIFA  = 11;
    localparam int WIIB  = 8;
    localparam int WIFB  = 12;
    localparam int WOI   = 15;
    localparam int WOF   = 14;
    localparam int ROUND = 1;
    localparam int WA    = WIIA + WIFA;
    localparam int WB    = WIIB + WIFB;
    localparam int WO    = WOI + WOF;
    localparam int LAT   = WOI + WOF + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [WA-1:0] dividend = '0;
    logic [WB-1:0] divisor = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [WO-1:0] out;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    fxp_div_seq #(
        .WIIA(WIIA), .WIFA(WIFA), .WIIB(WIIB), .WIFB(WIFB),
        .WOI(WOI), .WOF(WOF), .ROUND(ROUND)
    ) dut (
        .rstn(rstn), .clk(clk), .i_valid(i_valid), .i_ready(i_ready),
        .dividend(dividend), .divisor(divisor), .o_valid(o_valid),
        .o_ready(o_ready), .out(out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real-valued quotient scaled to WOF+1 fraction bits, then rounded and saturated
    function automatic void model(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                  output logic [WO-1:0] o, output logic ov);
        longint av, bv, am, bm, q, mag, lim_pos, lim_neg;
        bit neg;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        am = (av < 0) ? -av : av;
        bm = (bv < 0) ? -bv : bv;
        neg = (av < 0) != (bv < 0);
        lim_pos = (64'sd1 <<< (WO - 1)) - 1;
        lim_neg = 64'sd1 <<< (WO - 1);
        ov = 1'b1;
        if (bm == 0) begin
            o = (av >= 0) ? WO'(lim_pos) : WO'(-lim_neg);
        end else if ((am <<< WIFB) >= (bm <<< (WIFA + WOI - 1))) begin
            o = neg ? WO'(-lim_neg) : WO'(lim_pos);
        end else begin
            q = (am <<< (WOF + 1 + WIFB)) / (bm <<< WIFA);
            mag = (q + 1) / 2;
            if (!neg && mag > lim_pos) begin
                o = WO'(lim_pos);
            end else if (neg && mag > lim_neg) begin
                o = WO'(-lim_neg);
            end else begin
                ov = 1'b0;
                o = neg ? WO'(-mag) : WO'(mag);
            end
        end
    endfunction

    // Accept one pair, wait for the result (stray requests and operand noise
    // injected meanwhile), hold o_ready low for 'hold' cycles, then hand shake.
    task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input int hold,
                          output logic [WO-1:0] res, output logic ovf, output int lat);
        int guard;
        guard = 0;
        res = '0;
        ovf = 1'b0;
        @(negedge clk);
        while (!i_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", {63'd0, i_ready}, 64'd1);
        i_valid  = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        lat = 0;
        while (!o_valid && lat <= 100) begin
            i_valid  = 1'($urandom_range(0, 1));
            dividend = WA'($urandom);
            divisor  = WB'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        i_valid = 1'b0;
        if (!o_valid) begin
            check("result_timeout", {63'd0, o_valid}, 64'd1);
        end else begin
            res = out;
            ovf = overflow;
            for (int h = 0; h < hold; h++) begin
                i_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                check("hold_valid", {63'd0, o_valid}, 64'd1);
                check("hold_ready", {63'd0, i_ready}, 64'd0);
                check("hold_out", 64'(out), 64'(res));
                check("hold_ovf", {63'd0, overflow}, {63'd0, ovf});
            end
            i_valid = 1'b0;
            o_ready = 1'b1;
            @(posedge clk);
            #1;
            o_ready = 1'b0;
            check("post_hs_ready", {63'd0, i_ready}, 64'd1);
            check("post_hs_valid", {63'd0, o_valid}, 64'd0);
        end
    endtask

    typedef struct {
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        logic [WO-1:0] exp_out;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [WO-1:0] r;
        logic          ov;
        logic [WO-1:0] m;
        logic          mov;
        logic [WA-1:0] ra;
        logic [WB-1:0] rb;
        int            lat;

        vecs[0]  = '{21'h001800, 20'h02000, 29'h00006000, 1'b0};  //  3.0 /  2.0
        vecs[1]  = '{21'h001551, 20'h00000, 29'h0FFFFFFF, 1'b1};  //  +x  /  0
        vecs[2]  = '{21'h1FF800, 20'h00000, 29'h10000000, 1'b1};  // -1.0 /  0
        vecs[3]  = '{21'h1FF800, 20'h03000, 29'h1FFFEAAB, 1'b0};  // -1.0 /  3.0
        vecs[4]  = '{21'h0FFFFF, 20'h00001, 29'h0FFFFFFF, 1'b1};  // ratio ~2^21
        vecs[5]  = '{21'h100001, 20'h00001, 29'h10000000, 1'b1};  // negated
        vecs[6]  = '{21'h000800, 20'hFD000, 29'h1FFFEAAB, 1'b0};  //  1.0 / -3.0
        vecs[7]  = '{21'h1FF800, 20'hFD000, 29'h00001555, 1'b0};  // -1.0 / -3.0
        vecs[8]  = '{21'h000000, 20'h03000, 29'h00000000, 1'b0};  //  0   /  3.0
        vecs[9]  = '{21'h000800, 20'h00001, 29'h04000000, 1'b0};  //  1.0 / 2^-12
        vecs[10] = '{21'h002000, 20'h00001, 29'h0FFFFFFF, 1'b1};  // ratio == 2^14
        vecs[11] = '{21'h001000, 20'h03000, 29'h00002AAB, 1'b0};  //  2/3 rounds up
        vecs[12] = '{21'h001FFF, 20'h00001, 29'h0FFF8000, 1'b0};  // just below 2^14
        vecs[13] = '{21'h1FE001, 20'h00001, 29'h10008000, 1'b0};  // negative of above
        vecs[14] = '{21'h100000, 20'h80000, 29'h00010000, 1'b0};  // min / min = 4.0
        vecs[15] = '{21'h000000, 20'h00000, 29'h0FFFFFFF, 1'b1};  //  0 / 0

        // Reset state, asserted from time zero
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, i_ready}, 64'd1);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, r, ov, lat);
            check($sformatf("vec%0d_out", i), 64'(r), 64'(vecs[i].exp_out));
            check($sformatf("vec%0d_ovf", i), {63'd0, ov}, {63'd0, vecs[i].exp_ovf});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
        end

        // Back-pressure for 5 cycles, then a back-to-back second operation
        run_op(21'h001800, 20'h02000, 5, r, ov, lat);
        check("bp_out", 64'(r), 64'h6000);
        check("bp_ovf", {63'd0, ov}, 64'd0);
        run_op(21'h1FF800, 20'h03000, 0, r, ov, lat);
        check("b2b_out", 64'(r), 64'h1FFFEAAB);
        check("b2b_lat", 64'(lat), 64'(LAT));

        // Leave a saturated result on the outputs so reset has something to clear
        run_op(21'h1FF800, 20'h00000, 0, r, ov, lat);
        check("pre_rst_ovf", {63'd0, ov}, 64'd1);

        // Reset in CALC cycle 12 aborts the operation
        @(negedge clk);
        i_valid  = 1'b1;
        dividend = 21'h001800;
        divisor  = 20'h02000;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_valid", {63'd0, o_valid}, 64'd0);
        check("abort_ready", {63'd0, i_ready}, 64'd1);
        check("abort_out", 64'(out), 64'd0);
        check("abort_ovf", {63'd0, overflow}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < LAT + 5; c++) begin
                @(posedge clk);
                #1;
                if (o_valid) seen++;
            end
            check("abort_no_result", 64'(seen), 64'd0);
        end
        run_op(21'h1FF800, 20'h03000, 0, r, ov, lat);
        check("after_rst_out", 64'(r), 64'h1FFFEAAB);
        check("after_rst_ovf", {63'd0, ov}, 64'd0);
        check("after_rst_lat", 64'(lat), 64'(LAT));

        // Random operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = WA'($urandom) >> $urandom_range(0, WA - 1);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 9) == 0) begin
                rb = '0;
            end else begin
                rb = WB'($urandom) >> $urandom_range(0, WB - 1);
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            model(ra, rb, m, mov);
            run_op(ra, rb, $urandom_range(0, 2), r, ov, lat);
            check($sformatf("rnd%0d_out a=%0h b=%0h", i, ra, rb), 64'(r), 64'(m));
            check($sformatf("rnd%0d_ovf", i), {63'd0, ov}, {63'd0, mov});
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(LAT));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
